// File: rtl/elevator_pkg.sv
// Shared types and encodings for the three-floor elevator controller.
// Floors are carried internally as 3-bit one-hot vectors: bit 0 = floor 1.
package elevator_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_e;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam logic [1:0] FS_NONE = 2'd0;
    localparam logic [1:0] FS_F1   = 2'd1;
    localparam logic [1:0] FS_F2   = 2'd2;
    localparam logic [1:0] FS_F3   = 2'd3;

    localparam int DOOR_CYCLES_DEF = 8;

    function automatic logic [2:0] floor_mask(input logic [1:0] fs);
        case (fs)
            FS_NONE: return 3'b000;
            FS_F1:   return 3'b001;
            FS_F2:   return 3'b010;
            FS_F3:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] above_mask(input logic [1:0] fs);
        case (fs)
            FS_F1:   return 3'b110;
            FS_F2:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] below_mask(input logic [1:0] fs);
        case (fs)
            FS_F2:   return 3'b001;
            FS_F3:   return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/door_timer.sv
// Door-open countdown. Expires on the last open cycle so the door is high for
// exactly DOOR_CYCLES cycles, or early when the door-close button is held.
module door_timer
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clear_i,
    input  logic dc_i,
    output logic expired_o
);

    localparam int             TW       = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0]  LOAD_VAL = TW'(DOOR_CYCLES);
    localparam logic [TW-1:0]  ONE      = TW'(1);

    logic [TW-1:0] count_q, count_d;

    // NOTE: every variable written in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its peers, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q <= ONE) || dc_i;

endmodule

// File: rtl/elevator.sv
// Three-floor elevator controller: sticky call latches, travel FSM and
// registered door/direction outputs. Door countdown lives in door_timer.
module elevator
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UP1,
    input  logic       UP2,
    input  logic       DOWN2,
    input  logic       DOWN3,
    input  logic       FLOOR1,
    input  logic       FLOOR2,
    input  logic       FLOOR3,
    input  logic       DC,
    input  logic [1:0] FS,
    output logic       door,
    output logic [1:0] direction
);

    state_e     state_q, state_d;
    logic       door_q, door_d;
    logic [1:0] direction_q, direction_d;
    logic       last_up_q, last_up_d;
    logic [2:0] car_q, car_d;
    logic [2:0] up_q, up_d;
    logic [2:0] down_q, down_d;

    logic [2:0] btn_car, btn_up, btn_down;
    logic [2:0] fs_mask, req_vec;
    logic       at_req, req_above, req_below, cur_btn;
    logic       timer_load, timer_clear, timer_expired;

    assign btn_car  = {FLOOR3, FLOOR2, FLOOR1};
    assign btn_up   = {1'b0, UP2, UP1};
    assign btn_down = {DOWN3, DOWN2, 1'b0};

    assign fs_mask   = floor_mask(FS);
    assign req_vec   = car_q | up_q | down_q;
    assign at_req    = |(req_vec & fs_mask);
    assign req_above = |(req_vec & above_mask(FS));
    assign req_below = |(req_vec & below_mask(FS));
    assign cur_btn   = |((btn_car | btn_up | btn_down) & fs_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            door_q      <= 1'b0;
            direction_q <= DIR_IDLE;
            last_up_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            door_q      <= door_d;
            direction_q <= direction_d;
            last_up_q   <= last_up_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_up_d = last_up_q;
        unique case (state_q)
            S_IDLE: begin
                if (at_req) begin
                    state_d = S_DOOR_OPEN;
                end else if (req_above && (!req_below || last_up_q)) begin
                    state_d = S_MOVE_UP;
                end else if (req_below) begin
                    state_d = S_MOVE_DOWN;
                end
            end
            S_MOVE_UP: begin
                if (at_req)             state_d = S_DOOR_OPEN;
                else if (FS == FS_F3)   state_d = S_IDLE;
            end
            S_MOVE_DOWN: begin
                if (at_req)             state_d = S_DOOR_OPEN;
                else if (FS == FS_F1)   state_d = S_IDLE;
            end
            S_DOOR_OPEN: begin
                // A call at the open floor holds the door even if DC is pressed.
                if (!cur_btn && timer_expired) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_MOVE_UP)   last_up_d = 1'b1;
        if (state_d == S_MOVE_DOWN) last_up_d = 1'b0;
    end

    always_comb begin
        door_d      = 1'b0;
        direction_d = DIR_IDLE;
        case (state_d)
            S_MOVE_UP:   direction_d = DIR_UP;
            S_MOVE_DOWN: direction_d = DIR_DOWN;
            S_DOOR_OPEN: door_d      = 1'b1;
            default:     ;
        endcase
    end

    // Calls for the floor being served are dropped on the same edge, including
    // presses that arrive on that edge.
    always_comb begin
        car_d  = car_q  | btn_car;
        up_d   = up_q   | btn_up;
        down_d = down_q | btn_down;
        if (state_d == S_DOOR_OPEN) begin
            car_d  = car_d  & ~fs_mask;
            up_d   = up_d   & ~fs_mask;
            down_d = down_d & ~fs_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_q  <= '0;
            up_q   <= '0;
            down_q <= '0;
        end else begin
            car_q  <= car_d;
            up_q   <= up_d;
            down_q <= down_d;
        end
    end

    assign timer_load  = (state_d == S_DOOR_OPEN) && ((state_q != S_DOOR_OPEN) || cur_btn);
    assign timer_clear = (state_d != S_DOOR_OPEN);

    door_timer #(
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_door_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (timer_load),
        .clear_i  (timer_clear),
        .dc_i     (DC),
        .expired_o(timer_expired)
    );

    assign door      = door_q;
    assign direction = direction_q;

endmodule

// File: tb/tb_elevator.sv
// Scoreboard bench: each stimulus step queues the door/direction expected after
// that clock edge; a monitor pops and compares on every falling edge.
module tb_elevator;

    localparam logic [1:0] D_IDLE = 2'b00;
    localparam logic [1:0] D_UP   = 2'b01;
    localparam logic [1:0] D_DOWN = 2'b10;

    logic       clk, rst;
    logic       UP1, UP2, DOWN2, DOWN3, FLOOR1, FLOOR2, FLOOR3, DC;
    logic [1:0] FS;
    logic       door;
    logic [1:0] direction;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       door;
        logic [1:0] dir;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    elevator #(.DOOR_CYCLES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .UP1      (UP1),
        .UP2      (UP2),
        .DOWN2    (DOWN2),
        .DOWN3    (DOWN3),
        .FLOOR1   (FLOOR1),
        .FLOOR2   (FLOOR2),
        .FLOOR3   (FLOOR3),
        .DC       (DC),
        .FS       (FS),
        .door     (door),
        .direction(direction)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic clear_buttons();
        UP1 = 1'b0; UP2 = 1'b0; DOWN2 = 1'b0; DOWN3 = 1'b0;
        FLOOR1 = 1'b0; FLOOR2 = 1'b0; FLOOR3 = 1'b0; DC = 1'b0;
    endtask

    task automatic push(input logic d, input logic [1:0] dir, input string tag);
        exp_t e;
        e.door = d;
        e.dir  = dir;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // One clock edge: buttons set beforehand are sampled, then released.
    task automatic step(input logic d, input logic [1:0] dir, input string tag);
        @(posedge clk);
        #2;
        clear_buttons();
        push(d, dir, tag);
    endtask

    task automatic steps(input int n, input logic d, input logic [1:0] dir, input string tag);
        for (int i = 0; i < n; i++) step(d, dir, tag);
    endtask

    // Reset raised mid-cycle must clear outputs before the next rising edge.
    task automatic async_reset_step(input string tag);
        @(posedge clk);
        #2;
        clear_buttons();
        rst = 1'b1;
        push(1'b0, D_IDLE, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, {29'd0, door, direction}, {29'd0, e.door, e.dir});
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        clear_buttons();
        FS = 2'd1;

        // Reset and quiet hold at floor 1
        step(1'b0, D_IDLE, "reset");
        step(1'b0, D_IDLE, "reset");
        rst = 1'b0;
        steps(20, 1'b0, D_IDLE, "idle_hold");

        // Floor 1 -> 3, passing floor 2, default door time
        FLOOR3 = 1'b1; step(1'b0, D_IDLE, "a_latch");
        step(1'b0, D_UP, "a_go_up");
        FS = 2'd0; step(1'b0, D_UP, "a_between");
        FS = 2'd2; step(1'b0, D_UP, "a_pass_f2");
        FS = 2'd3; step(1'b1, D_IDLE, "a_open_f3");
        steps(7, 1'b1, D_IDLE, "a_door");
        step(1'b0, D_IDLE, "a_close");
        steps(2, 1'b0, D_IDLE, "a_idle");

        // Floor 3 -> 1 on a hall call, DC on second open cycle
        UP1 = 1'b1; step(1'b0, D_IDLE, "b_latch");
        step(1'b0, D_DOWN, "b_go_down");
        FS = 2'd2; step(1'b0, D_DOWN, "b_pass_f2");
        FS = 2'd0; step(1'b0, D_DOWN, "b_between");
        FS = 2'd1; step(1'b1, D_IDLE, "b_open_f1");
        step(1'b1, D_IDLE, "b_open_c1");
        DC = 1'b1; step(1'b0, D_IDLE, "b_dc_close");
        steps(2, 1'b0, D_IDLE, "b_idle");

        // Intermediate stop at floor 2 on a late hall call, then on to 3
        FLOOR3 = 1'b1; step(1'b0, D_IDLE, "c_latch");
        step(1'b0, D_UP, "c_go_up");
        FS = 2'd0; DOWN2 = 1'b1; step(1'b0, D_UP, "c_down2");
        FS = 2'd2; step(1'b1, D_IDLE, "c_stop_f2");
        steps(7, 1'b1, D_IDLE, "c_door2");
        step(1'b0, D_IDLE, "c_close2");
        step(1'b0, D_UP, "c_resume");
        FS = 2'd3; step(1'b1, D_IDLE, "c_open_f3");
        steps(7, 1'b1, D_IDLE, "c_door3");
        step(1'b0, D_IDLE, "c_close3");

        // Door reload at floor 2; same-floor press on the service edge
        FLOOR2 = 1'b1; step(1'b0, D_IDLE, "d_latch");
        step(1'b0, D_DOWN, "d_go_down");
        FS = 2'd2; DOWN2 = 1'b1; step(1'b1, D_IDLE, "d_open_f2");
        steps(5, 1'b1, D_IDLE, "d_door");
        FLOOR2 = 1'b1; step(1'b1, D_IDLE, "d_reload");
        steps(7, 1'b1, D_IDLE, "d_door_ext");
        step(1'b0, D_IDLE, "d_close");
        steps(5, 1'b0, D_IDLE, "d_no_pending");

        // Asynchronous reset while moving up drops the pending call
        FLOOR3 = 1'b1; step(1'b0, D_IDLE, "e_latch");
        step(1'b0, D_UP, "e_go_up");
        FS = 2'd0; step(1'b0, D_UP, "e_moving");
        async_reset_step("e_async_rst");
        step(1'b0, D_IDLE, "e_in_rst");
        rst = 1'b0; FS = 2'd2;
        steps(6, 1'b0, D_IDLE, "e_post_rst");

        // Calls both ways after reset: up wins, then serve floor 1 going down
        FLOOR1 = 1'b1; FLOOR3 = 1'b1; step(1'b0, D_IDLE, "g_latch");
        step(1'b0, D_UP, "g_rst_up");
        FS = 2'd3; step(1'b1, D_IDLE, "g_open_f3");
        steps(7, 1'b1, D_IDLE, "g_door3");
        step(1'b0, D_IDLE, "g_close3");
        step(1'b0, D_DOWN, "g_go_down");
        FS = 2'd2; step(1'b0, D_DOWN, "g_pass_f2");
        FS = 2'd1; step(1'b1, D_IDLE, "g_open_f1");
        steps(7, 1'b1, D_IDLE, "g_door1");
        step(1'b0, D_IDLE, "g_close1");

        // End-stop: sensor jumps past floor 2 to floor 3 while moving up
        FLOOR2 = 1'b1; step(1'b0, D_IDLE, "f_latch");
        step(1'b0, D_UP, "f_go_up");
        FS = 2'd0; step(1'b0, D_UP, "f_between");
        FS = 2'd3; step(1'b0, D_IDLE, "f_end_stop");
        step(1'b0, D_DOWN, "f_go_down");
        FS = 2'd2; step(1'b1, D_IDLE, "f_open_f2");
        steps(7, 1'b1, D_IDLE, "f_door2");
        step(1'b0, D_IDLE, "f_close2");

        // Calls both ways after travelling down: keep going down
        FLOOR1 = 1'b1; FLOOR3 = 1'b1; step(1'b0, D_IDLE, "h_latch");
        step(1'b0, D_DOWN, "h_keep_down");
        FS = 2'd1; step(1'b1, D_IDLE, "h_open_f1");

        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        #1;
        check("drain_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
